// File: rtl/fft_sample_double_buffer.sv
// Ping-pong sample buffer feeding the FFT controller.
// One bank fills from the sample stream while the other is read.
module fft_sample_double_buffer #(
   parameter int FFT_POINTS = 512,
   parameter int DATA_WIDTH = 24,
   parameter int CNT_WIDTH  = 16,
   localparam int AW = $clog2(FFT_POINTS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_sample_valid,
   input  logic [DATA_WIDTH-1:0] i_sample_data,
   output logic                  o_sample_ready,
   input  logic [AW-1:0]         i_buffer_read_addr,
   output logic [DATA_WIDTH-1:0] o_buffer_data,
   output logic                  o_data_ready,
   input  logic                  i_fft_busy,
   output logic                  o_overrun,
   output logic [CNT_WIDTH-1:0]  o_dropped_count,
   output logic [CNT_WIDTH-1:0]  o_frame_count,
   output logic                  o_write_bank
);

   typedef enum logic {
      W_FILL,
      W_FULL
   } wr_state_t;

   typedef enum logic [1:0] {
      R_EMPTY,
      R_READY,
      R_BUSY
   } rd_state_t;

   localparam logic [AW-1:0] LAST = AW'(FFT_POINTS - 1);

   wr_state_t wr_q, wr_nxt;
   rd_state_t rd_q, rd_nxt;

   logic [AW-1:0] wr_ptr, wr_ptr_nxt;
   logic          bank_nxt;
   logic          busy_d;
   logic          accept;
   logic          drop;
   logic          last;
   logic          swap;

   logic [DATA_WIDTH-1:0] bank0 [FFT_POINTS];
   logic [DATA_WIDTH-1:0] bank1 [FFT_POINTS];

   // State, pointer, bank select and busy history registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q         <= W_FILL;
         rd_q         <= R_EMPTY;
         wr_ptr       <= '0;
         o_write_bank <= 1'b0;
         busy_d       <= 1'b0;
      end else begin
         wr_q         <= wr_nxt;
         rd_q         <= rd_nxt;
         wr_ptr       <= wr_ptr_nxt;
         o_write_bank <= bank_nxt;
         busy_d       <= i_fft_busy;
      end
   end

   // Next-state logic for both sides; a swap overrides the fill/full decision
   always_comb begin
      wr_nxt     = wr_q;
      rd_nxt     = rd_q;
      wr_ptr_nxt = wr_ptr;
      bank_nxt   = o_write_bank;
      accept     = (wr_q == W_FILL) && i_sample_valid;
      drop       = (wr_q == W_FULL) && i_sample_valid;
      last       = accept && (wr_ptr == LAST);
      swap       = (rd_q == R_EMPTY) && ((wr_q == W_FULL) || last);

      if (accept) wr_ptr_nxt = wr_ptr + 1'b1;
      if (last)   wr_nxt     = W_FULL;

      case (rd_q)
         R_EMPTY: if (swap) rd_nxt = R_READY;
         R_READY: if (i_fft_busy) rd_nxt = R_BUSY;
         R_BUSY:  if (busy_d && !i_fft_busy) rd_nxt = R_EMPTY;
         default: rd_nxt = R_EMPTY;
      endcase

      if (swap) begin
         wr_nxt     = W_FILL;
         wr_ptr_nxt = '0;
         bank_nxt   = ~o_write_bank;
      end
   end

   // Overrun flag plus saturating drop and wrapping frame counters
   always_ff @(posedge clk) begin
      if (reset) begin
         o_overrun       <= 1'b0;
         o_dropped_count <= '0;
         o_frame_count   <= '0;
      end else begin
         if (drop) begin
            o_overrun <= 1'b1;
            if (o_dropped_count != '1)
               o_dropped_count <= o_dropped_count + 1'b1;
         end
         if (swap) o_frame_count <= o_frame_count + 1'b1;
      end
   end

   // Sample storage; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (accept) begin
         if (o_write_bank) bank1[wr_ptr] <= i_sample_data;
         else              bank0[wr_ptr] <= i_sample_data;
      end
   end

   assign o_buffer_data  = o_write_bank ? bank0[i_buffer_read_addr]
                                        : bank1[i_buffer_read_addr];
   assign o_sample_ready = (wr_q == W_FILL);
   assign o_data_ready   = (rd_q == R_READY);

endmodule

// File: tb/tb_fft_sample_double_buffer.sv
// Bench for the ping-pong FFT sample buffer.
// Frame-level queue model feeds a scoreboard checked at the falling edge.
module tb_fft_sample_double_buffer;

   localparam int N  = 8;
   localparam int DW = 24;
   localparam int CW = 4;
   localparam int AW = $clog2(N);

   logic          clk = 1'b0;
   logic          reset;
   logic          i_sample_valid;
   logic [DW-1:0] i_sample_data;
   logic          o_sample_ready;
   logic [AW-1:0] i_buffer_read_addr;
   logic [DW-1:0] o_buffer_data;
   logic          o_data_ready;
   logic          i_fft_busy;
   logic          o_overrun;
   logic [CW-1:0] o_dropped_count;
   logic [CW-1:0] o_frame_count;
   logic          o_write_bank;

   fft_sample_double_buffer #(
      .FFT_POINTS(N),
      .DATA_WIDTH(DW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .i_sample_valid    (i_sample_valid),
      .i_sample_data     (i_sample_data),
      .o_sample_ready    (o_sample_ready),
      .i_buffer_read_addr(i_buffer_read_addr),
      .o_buffer_data     (o_buffer_data),
      .o_data_ready      (o_data_ready),
      .i_fft_busy        (i_fft_busy),
      .o_overrun         (o_overrun),
      .o_dropped_count   (o_dropped_count),
      .o_frame_count     (o_frame_count),
      .o_write_bank      (o_write_bank)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          rdy;
      logic          dr;
      logic          ovr;
      logic          wb;
      logic          chk;
      logic [CW-1:0] drop;
      logic [CW-1:0] frm;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: frames as queues, read side as empty/ready/busy
   logic [DW-1:0] fillq[$];
   logic [DW-1:0] rd_frame[N];
   int            m_rs;
   bit            m_ovr;
   int            m_drop;
   int            m_frm;
   bit            m_bank;
   bit            m_bprev;
   int            bcnt;

   task automatic model_reset();
      fillq.delete();
      m_rs    = 0;
      m_ovr   = 0;
      m_drop  = 0;
      m_frm   = 0;
      m_bank  = 0;
      m_bprev = 0;
      bcnt    = 0;
   endtask

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] x);
      total++;
      if (a !== x) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
      end
   endtask

   // Monitor: pop one expectation per active cycle and compare outputs
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         chk("sample_ready", 32'(o_sample_ready), 32'(e.rdy));
         chk("data_ready", 32'(o_data_ready), 32'(e.dr));
         chk("overrun", 32'(o_overrun), 32'(e.ovr));
         chk("write_bank", 32'(o_write_bank), 32'(e.wb));
         chk("dropped", 32'(o_dropped_count), 32'(e.drop));
         chk("frames", 32'(o_frame_count), 32'(e.frm));
         if (e.chk) chk("rdata", 32'(o_buffer_data), 32'(e.data));
      end
   end

   task automatic step(input bit v, input logic [DW-1:0] d,
                       input bit b, input int a);
      exp_t             e;
      bit               acc;
      bit               swp;
      logic [DW-1:0]    nf[$];
      i_sample_valid     = v;
      i_sample_data      = d;
      i_fft_busy         = b;
      i_buffer_read_addr = AW'(a);
      e.rdy  = fillq.size() < N;
      e.dr   = (m_rs == 1);
      e.ovr  = m_ovr;
      e.wb   = m_bank;
      e.chk  = (m_rs != 0);
      e.drop = CW'(m_drop);
      e.frm  = CW'(m_frm);
      e.data = rd_frame[a % N];
      sbq.push_back(e);
      acc = v && e.rdy;
      if (v && !e.rdy) begin
         m_ovr = 1;
         if (m_drop < (1 << CW) - 1) m_drop++;
      end
      nf = fillq;
      if (acc) nf.push_back(d);
      swp = (m_rs == 0) && (nf.size() == N);
      if (m_rs == 1 && b) m_rs = 2;
      else if (m_rs == 2 && m_bprev && !b) m_rs = 0;
      if (swp) begin
         for (int i = 0; i < N; i++) rd_frame[i] = nf[i];
         nf.delete();
         m_rs   = 1;
         m_frm  = (m_frm + 1) % (1 << CW);
         m_bank = !m_bank;
      end
      fillq   = nf;
      m_bprev = b;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      i_sample_valid = 1'b0;
      i_fft_busy     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      bit b;
      reset              = 1'b1;
      i_sample_valid     = 1'b0;
      i_sample_data      = '0;
      i_fft_busy         = 1'b0;
      i_buffer_read_addr = '0;
      do_reset();

      // First frame, then combinational read sweep
      for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, i);

      // Busy handshake, second frame while locked, then overruns
      step(0, 0, 1, 0);
      for (int i = 9; i <= 16; i++) step(1, DW'(i), 1, i);
      for (int i = 17; i <= 19; i++) step(1, DW'(i), 1, i);
      for (int i = 20; i <= 30; i++) step(1, DW'(i), 0, i);
      for (int i = 0; i < 8; i++) step(0, 0, 0, i);

      // Continuous stream with 4-cycle busy pulses on each ready frame
      do_reset();
      for (int i = 0; i < 60; i++) begin
         if (m_rs == 1 && bcnt == 0) bcnt = 4;
         b = (bcnt > 0);
         if (bcnt > 0) bcnt--;
         step(1, DW'(100 + i), b, i);
      end

      // Reset in the middle of a frame
      for (int i = 0; i < 5; i++) step(1, DW'(200 + i), 0, i);
      do_reset();
      step(0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(1, DW'(300 + i), 0, i);
      for (int i = 0; i < 8; i++) step(0, 0, 0, i);

      // Drop counter saturation
      do_reset();
      for (int i = 0; i < 8; i++) step(1, DW'(400 + i), 0, i);
      step(0, 0, 1, 0);
      for (int i = 0; i < 8; i++) step(1, DW'(500 + i), 1, i);
      for (int i = 0; i < 24; i++) step(1, DW'(600 + i), 1, i);

      // Randomized traffic
      do_reset();
      b = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 4) == 0) b = !b;
         step($urandom_range(0, 3) != 0, DW'($urandom),
              b, int'($urandom_range(0, N - 1)));
      end

      step(0, 0, 0, 0);
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d expected 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
